// File: rtl/tpu_sram_loader_if.sv
// Host word stream plus the shared SRAM write port of the TPU SRAM loader.
// The loader owns the slave side: it consumes host words and drives the bank writes.
interface tpu_sram_loader_if #(
   parameter int SRAM_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH      = 10,
   parameter int BANK_NUM        = 8
);
   logic [SRAM_DATA_WIDTH-1:0] in_data;
   logic                       in_valid;
   logic                       in_ready;
   logic [BANK_NUM-1:0]        sram_wen_w;
   logic [BANK_NUM-1:0]        sram_wen_d;
   logic [ADDR_WIDTH-1:0]      sram_waddr;
   logic [SRAM_DATA_WIDTH-1:0] sram_wdata;

   modport master (
      output in_data, in_valid,
      input  in_ready, sram_wen_w, sram_wen_d, sram_waddr, sram_wdata
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, sram_wen_w, sram_wen_d, sram_waddr, sram_wdata
   );
endinterface

// File: rtl/tpu_sram_loader.sv
// Streams host words into 8 weight banks then 8 data banks (word n -> bank n%8, addr n/8),
// then starts the TPU core and waits for it to finish.
module tpu_sram_loader #(
   parameter int SRAM_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH      = 10,
   parameter int BANK_NUM        = 8
) (
   input  logic                  clk,
   input  logic                  srstn,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH:0]   load_len,
   input  logic                  load_abort,
   tpu_sram_loader_if.slave      bus,
   output logic                  tpu_start,
   input  logic                  tpu_done,
   output logic                  busy,
   output logic                  load_done
);
   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_D, START, WAIT_DONE} state_t;

   localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] LEN_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                     state_reg;
   logic [ADDR_WIDTH:0]        len_reg;
   logic [2:0]                 bank_idx_reg;
   logic [ADDR_WIDTH-1:0]      addr_cnt_reg;
   logic [BANK_NUM-1:0]        wen_w_reg;
   logic [BANK_NUM-1:0]        wen_d_reg;
   logic [ADDR_WIDTH-1:0]      waddr_reg;
   logic [SRAM_DATA_WIDTH-1:0] wdata_reg;
   logic                       tpu_start_reg;
   logic                       busy_reg;
   logic                       load_done_reg;

   logic                       loading;
   logic                       accept;
   logic                       last_word;
   logic [BANK_NUM-1:0]        bank_onehot;

   assign loading   = (state_reg == LOAD_W) || (state_reg == LOAD_D);
   assign accept    = bus.in_valid && loading;
   assign last_word = (bank_idx_reg == 3'd7) && ({1'b0, addr_cnt_reg} == (len_reg - LEN_ONE));

   generate
      for (genvar gi = 0; gi < BANK_NUM; gi++) begin : g_bank_sel
         assign bank_onehot[gi] = (bank_idx_reg == 3'(gi));
      end
   endgenerate

   always_ff @(posedge clk or negedge srstn) begin
      if (!srstn) begin
         state_reg     <= IDLE;
         len_reg       <= '0;
         bank_idx_reg  <= '0;
         addr_cnt_reg  <= '0;
         wen_w_reg     <= '0;
         wen_d_reg     <= '0;
         waddr_reg     <= '0;
         wdata_reg     <= '0;
         tpu_start_reg <= 1'b0;
         busy_reg      <= 1'b0;
         load_done_reg <= 1'b0;
      end else begin
         wen_w_reg     <= '0;
         wen_d_reg     <= '0;
         tpu_start_reg <= 1'b0;
         load_done_reg <= 1'b0;

         // An accepted word is always written, even when abort arrives in the same cycle.
         if (accept) begin
            if (state_reg == LOAD_W) wen_w_reg <= bank_onehot;
            else                     wen_d_reg <= bank_onehot;
            waddr_reg    <= addr_cnt_reg;
            wdata_reg    <= bus.in_data;
            bank_idx_reg <= bank_idx_reg + 3'd1;
            if (bank_idx_reg == 3'd7) addr_cnt_reg <= addr_cnt_reg + ADDR_WIDTH'(1);
         end

         case (state_reg)
            IDLE: begin
               if (load_start && (load_len != '0)) begin
                  len_reg      <= (load_len > MAX_LEN) ? MAX_LEN : load_len;
                  bank_idx_reg <= '0;
                  addr_cnt_reg <= '0;
                  state_reg    <= LOAD_W;
                  busy_reg     <= 1'b1;
               end
            end
            LOAD_W: begin
               if (load_abort) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (accept && last_word) begin
                  bank_idx_reg <= '0;
                  addr_cnt_reg <= '0;
                  state_reg    <= LOAD_D;
               end
            end
            LOAD_D: begin
               if (load_abort) begin
                  state_reg <= IDLE;
                  busy_reg  <= 1'b0;
               end else if (accept && last_word) begin
                  state_reg <= START;
               end
            end
            // One cycle gap after the last write so it commits before the core starts.
            START: begin
               tpu_start_reg <= 1'b1;
               state_reg     <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (tpu_done) begin
                  load_done_reg <= 1'b1;
                  state_reg     <= IDLE;
                  busy_reg      <= 1'b0;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = loading;
   assign bus.sram_wen_w = wen_w_reg;
   assign bus.sram_wen_d = wen_d_reg;
   assign bus.sram_waddr = waddr_reg;
   assign bus.sram_wdata = wdata_reg;
   assign tpu_start      = tpu_start_reg;
   assign busy           = busy_reg;
   assign load_done      = load_done_reg;
endmodule

// File: tb/tb_tpu_sram_loader.sv
// Randomized bench for tpu_sram_loader; expectations come from a word-count model
// that places word n of a region at bank n%8, address n/8.
module tb_tpu_sram_loader;
   logic        clk;
   logic        srstn;
   logic        load_start;
   logic [10:0] load_len;
   logic        load_abort;
   logic        tpu_start;
   logic        tpu_done;
   logic        busy;
   logic        load_done;

   tpu_sram_loader_if #(.SRAM_DATA_WIDTH(32), .ADDR_WIDTH(10), .BANK_NUM(8)) bus ();

   tpu_sram_loader #(.SRAM_DATA_WIDTH(32), .ADDR_WIDTH(10), .BANK_NUM(8)) dut (
      .clk        (clk),
      .srstn      (srstn),
      .load_start (load_start),
      .load_len   (load_len),
      .load_abort (load_abort),
      .bus        (bus),
      .tpu_start  (tpu_start),
      .tpu_done   (tpu_done),
      .busy       (busy),
      .load_done  (load_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum logic [1:0] {PH_IDLE, PH_LOAD, PH_START, PH_WAIT} ph_t;

   int          checks = 0;
   int          errors = 0;
   ph_t         m_phase;
   int          m_len;
   int          m_count;
   logic [9:0]  m_waddr;
   logic [31:0] m_wdata;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = PH_IDLE;
      m_len   = 0;
      m_count = 0;
      m_waddr = '0;
      m_wdata = '0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(0));
      check({tag, "_wen_w"}, 64'(bus.sram_wen_w), 64'(0));
      check({tag, "_wen_d"}, 64'(bus.sram_wen_d), 64'(0));
      check({tag, "_waddr"}, 64'(bus.sram_waddr), 64'(0));
      check({tag, "_wdata"}, 64'(bus.sram_wdata), 64'(0));
      check({tag, "_tpu_start"}, 64'(tpu_start), 64'(0));
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_load_done"}, 64'(load_done), 64'(0));
   endtask

   // One clock cycle: drive, predict, clock, compare. Called at posedge+1.
   task automatic cycle(input logic st, input logic [10:0] len, input logic ab,
                        input logic v, input logic [31:0] data, input logic dn);
      logic       acc;
      int         tot, k;
      logic [7:0] ew, ed;
      logic       es, eld;
      ph_t        nxt;
      load_start   = st;
      load_len     = len;
      load_abort   = ab;
      bus.in_valid = v;
      bus.in_data  = data;
      tpu_done     = dn;
      check("in_ready", 64'(bus.in_ready), 64'(m_phase == PH_LOAD));
      acc = v && (m_phase == PH_LOAD);
      ew  = '0;
      ed  = '0;
      es  = 1'b0;
      eld = 1'b0;
      nxt = m_phase;
      case (m_phase)
         PH_IDLE: if (st && len != 0) begin
            nxt     = PH_LOAD;
            m_len   = (int'(len) > 1024) ? 1024 : int'(len);
            m_count = 0;
         end
         PH_LOAD: begin
            if (acc) begin
               tot = 8 * m_len;
               k   = m_count % tot;
               if (m_count < tot) ew[k % 8] = 1'b1;
               else               ed[k % 8] = 1'b1;
               m_waddr = 10'(k / 8);
               m_wdata = data;
               m_count++;
               if (m_count == 2 * tot) nxt = PH_START;
            end
            if (ab) nxt = PH_IDLE;
         end
         PH_START: begin
            es  = 1'b1;
            nxt = PH_WAIT;
         end
         default: if (dn) begin
            eld = 1'b1;
            nxt = PH_IDLE;
         end
      endcase
      @(posedge clk);
      #1;
      check("wen_w", 64'(bus.sram_wen_w), 64'(ew));
      check("wen_d", 64'(bus.sram_wen_d), 64'(ed));
      check("waddr", 64'(bus.sram_waddr), 64'(m_waddr));
      check("wdata", 64'(bus.sram_wdata), 64'(m_wdata));
      check("tpu_start", 64'(tpu_start), 64'(es));
      check("load_done", 64'(load_done), 64'(eld));
      check("busy", 64'(busy), 64'(nxt != PH_IDLE));
      m_phase = nxt;
   endtask

   // Asynchronous reset dropped mid-cycle; outputs must clear before any clock edge.
   task automatic apply_reset_mid();
      load_start   = 1'b0;
      load_abort   = 1'b0;
      bus.in_valid = 1'b0;
      tpu_done     = 1'b0;
      #2;
      srstn = 1'b0;
      #1;
      check_all_zero("async_rst");
      model_reset();
      @(posedge clk);
      #1;
      srstn = 1'b1;
   endtask

   // vmode: 0 valid held high, 1 toggling, 2 random.
   task automatic run_load(input int len, input int vmode, input int abort_at,
                           input int rst_at, input bit seq, input bit noise);
      int          guard, wait_n;
      logic        v, st, ab, dn;
      logic [31:0] data;
      data = seq ? 32'(0) : $urandom;
      cycle(1'b1, 11'(len), 1'b0, 1'b0, data, 1'b0);
      guard  = 0;
      wait_n = 0;
      while (m_phase != PH_IDLE && guard < 40000) begin
         if (rst_at >= 0 && m_phase == PH_LOAD && m_count == rst_at) begin
            apply_reset_mid();
            break;
         end
         case (vmode)
            0:       v = 1'b1;
            1:       v = (guard % 2 == 0);
            default: v = 1'($urandom_range(0, 1));
         endcase
         ab = (abort_at >= 0 && m_phase == PH_LOAD && m_count == abort_at);
         if (ab) v = 1'b0;
         if (noise && m_phase != PH_LOAD && $urandom_range(0, 3) == 0) ab = 1'b1;
         st = noise && ($urandom_range(0, 7) == 0);
         if (m_phase == PH_WAIT) begin
            dn = (wait_n >= 5);
            wait_n++;
         end else begin
            dn = noise && ($urandom_range(0, 5) == 0);
         end
         data = seq ? 32'(m_count) : $urandom;
         cycle(st, 11'($urandom_range(1, 5)), ab, v, data, dn);
         guard++;
      end
      if (guard >= 40000) check("load_timeout", 64'(1), 64'(0));
   endtask

   initial begin
      srstn        = 1'b0;
      load_start   = 1'b0;
      load_len     = '0;
      load_abort   = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      tpu_done     = 1'b0;
      model_reset();
      #3;
      check_all_zero("reset");
      @(posedge clk);
      #1;
      srstn = 1'b1;
      cycle(1'b0, 11'd0, 1'b0, 1'b0, 32'd0, 1'b0);

      // len=2, sequential data, valid held high, then toggling valid
      run_load(2, 0, -1, -1, 1'b1, 1'b0);
      run_load(2, 1, -1, -1, 1'b1, 1'b0);

      // len=0 is a no-op
      cycle(1'b1, 11'd0, 1'b0, 1'b1, 32'hdead_beef, 1'b0);
      cycle(1'b0, 11'd0, 1'b0, 1'b1, 32'hdead_beef, 1'b0);

      // clamped length: 1500 -> 1024 words per bank
      run_load(1500, 0, -1, -1, 1'b0, 1'b0);

      // abort after 10 weight words, then a fresh len=1 load
      run_load(2, 0, 10, -1, 1'b1, 1'b0);
      cycle(1'b0, 11'd0, 1'b0, 1'b0, 32'd0, 1'b0);
      run_load(1, 0, -1, -1, 1'b1, 1'b0);

      // reset during LOAD_D, then a lone tpu_done must not produce load_done
      run_load(2, 0, -1, 19, 1'b1, 1'b0);
      cycle(1'b0, 11'd0, 1'b0, 1'b0, 32'd0, 1'b1);
      cycle(1'b0, 11'd0, 1'b0, 1'b0, 32'd0, 1'b0);

      // randomized loads with spurious start/abort/done noise
      for (int i = 0; i < 6; i++) begin
         run_load($urandom_range(1, 4), 2, -1, -1, 1'b0, 1'b1);
         cycle(1'b0, 11'd0, 1'b0, 1'b0, $urandom, 1'($urandom_range(0, 1)));
      end
      run_load(3, 2, $urandom_range(0, 40), -1, 1'b0, 1'b0);
      cycle(1'b0, 11'd0, 1'b0, 1'b0, 32'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tpu_sram_loader.md
Name: tpu_sram_loader

Overview:
- Upstream feeder for the TPU core.
- Accepts a host word stream over a valid/ready handshake and writes it into the eight weight SRAM banks, then into the eight data SRAM banks, using interleaved bank/address order.
- When both regions are full, it pulses tpu_start to the TPU core and holds busy until the core returns tpu_done.

Parameters:
- SRAM_DATA_WIDTH, 32, width of one host word and one SRAM word.
- ADDR_WIDTH, 10, SRAM bank address width (depth 1024).
- BANK_NUM, 8, banks per region (weight or data). Fixed at 8: bank index is 3 bits.

Ports:
- clk  input  1  clock
- srstn  input  1  asynchronous active-low reset
- load_start  input  1  one-cycle request to begin a load
- load_len  input  ADDR_WIDTH+1  words per bank; sampled on accepted load_start
- load_abort  input  1  synchronous abort of an in-progress load
- in_data  input  SRAM_DATA_WIDTH  host word
- in_valid  input  1  host word valid
- in_ready  output  1  loader accepts in_data this cycle
- sram_wen_w  output  BANK_NUM  one-hot write enables, weight banks w0..w7
- sram_wen_d  output  BANK_NUM  one-hot write enables, data banks d0..d7
- sram_waddr  output  ADDR_WIDTH  shared write address
- sram_wdata  output  SRAM_DATA_WIDTH  shared write data
- tpu_start  output  1  one-cycle start pulse to the TPU core
- tpu_done  input  1  completion from the TPU core
- busy  output  1  high in every state except IDLE
- load_done  output  1  one-cycle pulse when the loader returns to IDLE after tpu_done

Behaviour:
- Reset (srstn low, asynchronous): state=IDLE, all counters 0. All outputs 0, including in_ready, wen, waddr, wdata, tpu_start, busy and load_done.
- Reset asserted mid-load clears everything immediately. Partially written SRAM contents are left as they are.
- States: IDLE, LOAD_W, LOAD_D, START, WAIT_DONE.
- IDLE:
  - load_start with load_len != 0: latch len = min(load_len, 1024), clear bank_idx/addr_cnt, go to LOAD_W.
  - load_len == 0: no-op, stay IDLE, no pulses.
  - load_start in any other state is ignored.
- LOAD_W / LOAD_D:
  - in_ready=1 (combinational from state; no other backpressure).
  - Accept = in_valid & in_ready.
  - On accept, next cycle (registered, latency 1):
    - wen of region bit bank_idx = 1, other wen bits 0;
    - sram_waddr = addr_cnt;
    - sram_wdata = in_data.
  - Without an accept, all wen are 0; waddr/wdata hold their last value.
  - Counter order: bank_idx increments 0→7. On wrap to 0, addr_cnt increments. So word n goes to bank n mod 8, address n div 8.
  - Last word of a region is accept with bank_idx==7 and addr_cnt==len-1.
  - LOAD_W last word: go to LOAD_D, clear counters.
  - LOAD_D last word: go to START.
  - Total accepted words = 16*len.
- START:
  - in_ready=0.
  - tpu_start=1 for exactly one cycle, asserted the cycle after the final write-enable cycle, so the last SRAM write commits before start.
  - Then go to WAIT_DONE.
- WAIT_DONE:
  - in_ready=0.
  - On tpu_done=1: go to IDLE, load_done=1 for one cycle.
  - tpu_done while not in WAIT_DONE is ignored.
- load_abort:
  - In LOAD_W or LOAD_D: go to IDLE next cycle. No tpu_start, no load_done.
  - If abort and accept occur in the same cycle, the word is still written (the registered write issues) and the state then goes to IDLE.
  - load_abort in START or WAIT_DONE is ignored, so a started TPU run always completes.
- busy = (state != IDLE), registered with the state.
- addr_cnt is ADDR_WIDTH bits. len=1024 uses the full range 0..1023 with no overflow.

Test Plan:
- len=2, 32 words 0x00000000..0x0000001F with in_valid held high:
  - weight writes: w0@0=0x0, w1@0=0x1, …, w7@0=0x7, w0@1=0x8, …, w7@1=0xF;
  - data writes: d0@0=0x10 … d7@1=0x1F;
  - tpu_start pulses once, one cycle after the d7@1 write;
  - tpu_done 5 cycles later gives a load_done pulse and busy=0.
- Same load with in_valid toggling 1/0 every cycle: identical write sequence, no write-enable in gap cycles, waddr/wdata held.
- len=0 start: no state change, busy stays 0, no writes.
- len=1500: clamped to 1024; 16384 words accepted; last writes are w7@1023 and d7@1023; tpu_start follows.
- load_abort after 10 weight words: exactly 10 writes (w0..w7@0, w0..w1@1), back to IDLE, no tpu_start. A new len=1 load then starts at w0@0.
- srstn dropped during LOAD_D: all outputs 0 immediately. After release, in IDLE; tpu_done pulse alone causes no load_done.
